// File: rtl/two_sum_stream_source.sv
// Plays a locally loaded signed array out as a number stream with a constant target, then captures the solver's first result.
// Latency: first beat 1 cycle after an accepted start; done pulses len+3 cycles after start when unpaused.
// Backpressure: pause suppresses the next beat and holds the pointer; start/load are ignored while a transfer runs.
module two_sum_stream_source #(
    parameter  int DATA_WIDTH = 2,
    parameter  int ARRAY_SIZE = 2 ** DATA_WIDTH,
    localparam int IW         = $clog2(ARRAY_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [IW-1:0]         load_index,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [IW:0]           length,
    input  logic [DATA_WIDTH-1:0] target_in,
    input  logic                  start,
    input  logic                  pause,
    output logic [DATA_WIDTH-1:0] number,
    output logic                  number_valid,
    output logic                  number_last,
    output logic [DATA_WIDTH-1:0] target,
    input  logic [IW-1:0]         index1,
    input  logic [IW-1:0]         index2,
    input  logic                  index_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [IW-1:0]         result_index1,
    output logic [IW-1:0]         result_index2,
    output logic                  error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [IW:0]   L_SIZE = (IW + 1)'(ARRAY_SIZE);
    localparam logic [IW:0]   L_TWO  = (IW + 1)'(2);
    localparam logic [IW:0]   L_ONE  = (IW + 1)'(1);
    localparam logic [IW-1:0] P_ONE  = IW'(1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_mem [ARRAY_SIZE];
    logic [IW-1:0]         r_ptr;
    logic [IW:0]           r_len;
    logic                  r_wcnt;
    logic [DATA_WIDTH-1:0] r_number;
    logic                  r_number_valid;
    logic                  r_number_last;
    logic [DATA_WIDTH-1:0] r_target;
    logic                  r_done;
    logic                  r_found;
    logic [IW-1:0]         r_res1;
    logic [IW-1:0]         r_res2;
    logic                  r_error;

    logic                  w_start_ok;
    logic                  w_last;
    logic                  w_capture;
    logic [IW:0]           w_len_sat;

    assign w_start_ok = start && (length >= L_TWO);
    assign w_len_sat  = (length > L_SIZE) ? L_SIZE : length;
    assign w_last     = ({1'b0, r_ptr} == (r_len - L_ONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: WAIT spans two cycles, FIN is the cycle that raises done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_STREAM;
            S_STREAM: if (!pause && w_last) w_next = S_WAIT;
            S_WAIT:   if (r_wcnt) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode: busy and the result-capture window.
    always_comb begin
        busy      = (r_state == S_STREAM) || (r_state == S_WAIT);
        w_capture = busy && index_valid && !r_found;
    end

    // Array storage, writable only when idle; a same-cycle start streams the new word.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && load_valid) begin
            r_mem[load_index] <= load_data;
        end
    end

    // Registered datapath: stream beats, WAIT counter, result latch and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= '0;
            r_len          <= '0;
            r_wcnt         <= 1'b0;
            r_number       <= '0;
            r_number_valid <= 1'b0;
            r_number_last  <= 1'b0;
            r_target       <= '0;
            r_done         <= 1'b0;
            r_found        <= 1'b0;
            r_res1         <= '0;
            r_res2         <= '0;
            r_error        <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_capture) begin
                r_found <= 1'b1;
                r_res1  <= index1;
                r_res2  <= index2;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_start_ok) begin
                            r_error <= 1'b1;
                        end else begin
                            r_len    <= w_len_sat;
                            r_target <= target_in;
                            r_found  <= 1'b0;
                            r_res1   <= '0;
                            r_res2   <= '0;
                            r_ptr    <= '0;
                            r_wcnt   <= 1'b0;
                        end
                    end
                end
                S_STREAM: begin
                    if (pause) begin
                        r_number_valid <= 1'b0;
                        r_number_last  <= 1'b0;
                    end else begin
                        r_number       <= r_mem[r_ptr];
                        r_number_valid <= 1'b1;
                        r_number_last  <= w_last;
                        r_ptr          <= r_ptr + P_ONE;
                    end
                end
                S_WAIT: begin
                    r_number_valid <= 1'b0;
                    r_number_last  <= 1'b0;
                    r_wcnt         <= ~r_wcnt;
                end
                S_FIN: begin
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign number        = r_number;
    assign number_valid  = r_number_valid;
    assign number_last   = r_number_last;
    assign target        = r_target;
    assign done          = r_done;
    assign found         = r_found;
    assign result_index1 = r_res1;
    assign result_index2 = r_res2;
    assign error         = r_error;

endmodule

// File: tb/tb_two_sum_stream_source.sv
module tb_two_sum_stream_source;

    localparam int DW = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic [IW-1:0] load_index = '0;
    logic [DW-1:0] load_data = '0;
    logic [IW:0]   length = '0;
    logic [DW-1:0] target_in = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [DW-1:0] number;
    logic          number_valid;
    logic          number_last;
    logic [DW-1:0] target;
    logic [IW-1:0] index1 = '0;
    logic [IW-1:0] index2 = '0;
    logic          index_valid = 1'b0;
    logic          busy;
    logic          done;
    logic          found;
    logic [IW-1:0] result_index1;
    logic [IW-1:0] result_index2;
    logic          error;

    two_sum_stream_source #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_index(load_index), .load_data(load_data),
        .length(length), .target_in(target_in), .start(start), .pause(pause),
        .number(number), .number_valid(number_valid), .number_last(number_last),
        .target(target),
        .index1(index1), .index2(index2), .index_valid(index_valid),
        .busy(busy), .done(done), .found(found),
        .result_index1(result_index1), .result_index2(result_index2),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { int num; int last; int tgt; } beat_t;
    typedef struct { int fnd; int r1; int r2; int lat; } fin_t;

    beat_t beat_q[$];
    fin_t  fin_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference solver: reports the later/earlier index of a pair summing to target, one cycle after the beat.
    int seen_v[4];
    int seen_n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            index_valid <= 1'b0;
            seen_n = 0;
        end else begin
            index_valid <= 1'b0;
            if (number_valid) begin
                automatic int v = int'($signed(number));
                automatic bit hit = 0;
                for (int j = 0; j < seen_n; j++) begin
                    if (!hit && (seen_v[j] + v == int'($signed(target)))) begin
                        hit = 1;
                        index_valid <= 1'b1;
                        index1 <= IW'(seen_n);
                        index2 <= IW'(j);
                    end
                end
                seen_v[seen_n] = v;
                seen_n = number_last ? 0 : seen_n + 1;
            end
        end
    end

    // Monitor: pops and compares every beat and every done pulse.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            if (number_valid) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    automatic beat_t b = beat_q.pop_front();
                    chk("beat_number", int'($signed(number)), b.num);
                    chk("beat_last", int'(number_last), b.last);
                    chk("beat_target", int'($signed(target)), b.tgt);
                end
            end
            if (done) begin
                done_cnt++;
                if (fin_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    automatic fin_t f = fin_q.pop_front();
                    chk("done_found", int'(found), f.fnd);
                    chk("done_res1", int'(result_index1), f.r1);
                    chk("done_res2", int'(result_index2), f.r2);
                    chk("done_latency", cyc - start_cyc, f.lat);
                    chk("done_busy", int'(busy), 0);
                end
            end
        end
    end

    task automatic load4(input int v0, input int v1, input int v2, input int v3);
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_index = IW'(i);
            load_data  = DW'(v[i]);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic push_beats(input int v0, input int v1, input int v2, input int v3, input int tgt);
        beat_q.push_back('{v0, 0, tgt});
        beat_q.push_back('{v1, 0, tgt});
        beat_q.push_back('{v2, 0, tgt});
        beat_q.push_back('{v3, 1, tgt});
    endtask

    task automatic go(input int len, input int tgt);
        @(negedge clk);
        length    = (IW + 1)'(len);
        target_in = DW'(tgt);
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = done_cnt;
        int k = 0;
        while (done_cnt == n0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == n0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #12;
        chk("rst_outputs", int'({number, number_valid, number_last, target, busy,
                                 done, found, result_index1, result_index2, error}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Pair 1+0 at indices 0 and 2.
        load4(1, -2, 0, 1);
        push_beats(1, -2, 0, 1, 1);
        fin_q.push_back('{1, 2, 0, 7});
        go(4, 1);
        chk("busy_stream", int'(busy), 1);
        wait_done();
        chk("found_held", int'(found), 1);
        chk("res1_held", int'(result_index1), 2);

        // Target 0 has no pair; length 7 saturates to 4 beats.
        push_beats(1, -2, 0, 1, 0);
        fin_q.push_back('{0, 0, 0, 7});
        go(7, 0);
        wait_done();

        // Short lengths are rejected.
        for (int l = 0; l < 2; l++) begin
            go(l, 1);
            chk("err_pulse", int'(error), 1);
            chk("err_busy", int'(busy), 0);
            @(negedge clk);
            chk("err_clear", int'(error), 0);
        end

        // Pause on STREAM cycles 2 and 3 stretches done to 9 cycles.
        push_beats(1, -2, 0, 1, 1);
        fin_q.push_back('{1, 2, 0, 9});
        go(4, 1);
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pause = 1'b0;
        wait_done();

        // start and load during STREAM are ignored.
        push_beats(1, -2, 0, 1, 1);
        fin_q.push_back('{1, 2, 0, 7});
        go(4, 1);
        load_valid = 1'b1;
        load_index = '0;
        load_data  = DW'(-1);
        start      = 1'b1;
        length     = 3'd2;
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
        wait_done();
        push_beats(1, -2, 0, 1, 0);
        fin_q.push_back('{0, 0, 0, 7});
        go(4, 0);
        wait_done();

        // Async reset between edges mid-STREAM.
        push_beats(1, -2, 0, 1, 1);
        go(4, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", int'({number, number_valid, number_last, target, busy,
                                    done, found, result_index1, result_index2, error}), 0);
        chk("midrst_beats_left", beat_q.size(), 3);
        beat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        push_beats(1, -2, 0, 1, 1);
        fin_q.push_back('{1, 2, 0, 7});
        go(4, 1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("beats_drained", beat_q.size(), 0);
        chk("dones_drained", fin_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
